// File: rtl/seven_segment_pkg.sv
// Shared definitions for the seven-segment display path: pattern type, the
// sixteen hex glyphs, the blank glyph and the reader FSM state encoding.
package seven_segment_pkg;

  // Segment order {A,B,C,D,E,F,G}, A in bit 6, active-high.
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0     = 7'b1111110;
  localparam seg_t SEG_1     = 7'b0110000;
  localparam seg_t SEG_2     = 7'b1101101;
  localparam seg_t SEG_3     = 7'b1111001;
  localparam seg_t SEG_4     = 7'b0110011;
  localparam seg_t SEG_5     = 7'b1011011;
  localparam seg_t SEG_6     = 7'b1011111;
  localparam seg_t SEG_7     = 7'b1110000;
  localparam seg_t SEG_8     = 7'b1111111;
  localparam seg_t SEG_9     = 7'b1111011;
  localparam seg_t SEG_A     = 7'b1110111;
  localparam seg_t SEG_B     = 7'b0011111;
  localparam seg_t SEG_C     = 7'b1001110;
  localparam seg_t SEG_D     = 7'b0111101;
  localparam seg_t SEG_E     = 7'b1001111;
  localparam seg_t SEG_F     = 7'b1000111;
  localparam seg_t SEG_BLANK = 7'b0000000;

  localparam int         CNT_W   = 4;
  localparam logic [3:0] CNT_MAX = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLING,
    ST_HELD
  } state_t;

  // Single source of truth for the glyph set; the encoder and decoder both use it.
  function automatic seg_t hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0: hex_to_seg = SEG_0;
      4'h1: hex_to_seg = SEG_1;
      4'h2: hex_to_seg = SEG_2;
      4'h3: hex_to_seg = SEG_3;
      4'h4: hex_to_seg = SEG_4;
      4'h5: hex_to_seg = SEG_5;
      4'h6: hex_to_seg = SEG_6;
      4'h7: hex_to_seg = SEG_7;
      4'h8: hex_to_seg = SEG_8;
      4'h9: hex_to_seg = SEG_9;
      4'hA: hex_to_seg = SEG_A;
      4'hB: hex_to_seg = SEG_B;
      4'hC: hex_to_seg = SEG_C;
      4'hD: hex_to_seg = SEG_D;
      4'hE: hex_to_seg = SEG_E;
      default: hex_to_seg = SEG_F;
    endcase
  endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational inverse of the hex glyph table: 7-bit pattern to {legal, nibble}.
module seg_pattern_decode
  import seven_segment_pkg::*;
(
  input  seg_t       i_seg,
  output logic       o_legal,
  output logic [3:0] o_nibble
);

  always_comb begin
    // NOTE: every output gets a default before the search so no path leaves it
    // unassigned, which would otherwise infer a latch.
    o_legal  = 1'b0;
    o_nibble = 4'h0;
    for (int n = 0; n < 16; n++) begin
      if (hex_to_seg(4'(n)) == i_seg) begin
        o_legal  = 1'b1;
        o_nibble = 4'(n);
      end
    end
  end

endmodule

// File: rtl/seven_segment_reader.sv
// Monitor for a multiplexed seven-segment bus: debounces {dig_sel, seg_in},
// recovers the hex digit per position, tracks full frames and flags errors.
module seven_segment_reader
  import seven_segment_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int SETTLE = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg_in,
  input  logic [DIGITS-1:0]     dig_sel,
  input  logic                  err_clr,
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     digit_valid,
  output logic                  frame_valid,
  output logic                  err
);

  localparam int         SMP_W     = DIGITS + 7;
  localparam logic [3:0] SETTLE_M1 = CNT_W'(SETTLE - 1);

  logic [SMP_W-1:0]    w_smp_in;
  logic [SMP_W-1:0]    r_smp;
  logic                w_same;
  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt, w_cnt_inc;
  logic                w_capture;
  logic                w_legal;
  logic [3:0]          w_nibble;
  logic                w_multi_hot;
  logic [4*DIGITS-1:0] r_value, w_value_nxt;
  logic [DIGITS-1:0]   r_digit_valid, w_digit_valid_nxt;
  logic [DIGITS-1:0]   r_seen, w_seen_nxt;
  logic                r_frame_valid, w_frame_valid_nxt;
  logic                r_err, w_err_nxt, w_err_evt;

  assign w_smp_in    = {dig_sel, seg_in};
  assign w_same      = (w_smp_in == r_smp);
  assign w_cnt_inc   = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 4'd1;
  assign w_multi_hot = ((dig_sel & (dig_sel - DIGITS'(1))) != '0);

  seg_pattern_decode u_decode (
    .i_seg    (seg_in),
    .o_legal  (w_legal),
    .o_nibble (w_nibble)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_state_nxt = ST_SETTLING;
        w_cnt_nxt   = '0;
      end
      ST_SETTLING: begin
        if (!w_same) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == SETTLE_M1) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_HELD;
          w_cnt_nxt   = w_cnt_inc;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      ST_HELD: begin
        if (!w_same) begin
          w_state_nxt = ST_SETTLING;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // A capture with a blank select touches nothing; multi-hot only raises err.
  always_comb begin
    w_value_nxt       = r_value;
    w_digit_valid_nxt = r_digit_valid;
    w_seen_nxt        = r_seen;
    w_frame_valid_nxt = 1'b0;
    w_err_evt         = 1'b0;
    if (w_capture) begin
      if (w_multi_hot) begin
        w_err_evt = 1'b1;
      end else begin
        for (int i = 0; i < DIGITS; i++) begin
          if (dig_sel[i]) begin
            if (w_legal) begin
              w_value_nxt[4*i +: 4] = w_nibble;
              w_digit_valid_nxt[i]  = 1'b1;
              w_seen_nxt[i]         = 1'b1;
            end else begin
              w_digit_valid_nxt[i] = 1'b0;
              w_seen_nxt[i]        = 1'b0;
              w_err_evt            = 1'b1;
            end
          end
        end
      end
      if (&w_seen_nxt) begin
        w_frame_valid_nxt = 1'b1;
        w_seen_nxt        = '0;
      end
    end
    // An error event in the same cycle as err_clr keeps err set.
    w_err_nxt = w_err_evt | (r_err & ~err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: digit registers are reset along with control state because the
    // recovered value is architecturally visible and must read 0 after reset.
    if (!rst_n) begin
      r_smp         <= '0;
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_value       <= '0;
      r_digit_valid <= '0;
      r_seen        <= '0;
      r_frame_valid <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      r_smp         <= w_smp_in;
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_value       <= w_value_nxt;
      r_digit_valid <= w_digit_valid_nxt;
      r_seen        <= w_seen_nxt;
      r_frame_valid <= w_frame_valid_nxt;
      r_err         <= w_err_nxt;
    end
  end

  assign value       = r_value;
  assign digit_valid = r_digit_valid;
  assign frame_valid = r_frame_valid;
  assign err         = r_err;

endmodule

// File: tb/tb_seven_segment_reader.sv
// Bench for seven_segment_reader: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a run-length model.
module tb_seven_segment_reader;

  localparam int DIGITS = 4;
  localparam int SETTLE = 3;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [6:0]          seg_in = '0;
  logic [DIGITS-1:0]   dig_sel = '0;
  logic                err_clr = 1'b0;
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   digit_valid;
  logic                frame_valid;
  logic                err;

  always #5 clk = ~clk;

  seven_segment_reader #(.DIGITS(DIGITS), .SETTLE(SETTLE)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_in      (seg_in),
    .dig_sel     (dig_sel),
    .err_clr     (err_clr),
    .value       (value),
    .digit_valid (digit_valid),
    .frame_valid (frame_valid),
    .err         (err)
  );

  int n_total = 0;
  int n_pass  = 0;
  bit check_en = 1'b0;

  logic [6:0] pat_tab [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: a capture happens on the edge where the same sample has been seen
  // SETTLE+1 edges in a row (counting the edge that introduced it).
  logic [3:0]        m_val [DIGITS];
  logic [DIGITS-1:0] m_dv, m_seen;
  logic              m_fv, m_err;
  logic [DIGITS+6:0] m_prev;
  int                m_run;
  bit                m_first;

  function automatic int lookup(input logic [6:0] p);
    lookup = -1;
    for (int n = 0; n < 16; n++) if (pat_tab[n] == p) lookup = n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DIGITS; i++) m_val[i] = 4'h0;
    m_dv = '0; m_seen = '0; m_fv = 1'b0; m_err = 1'b0;
    m_prev = '0; m_run = 0; m_first = 1'b1;
  endtask

  task automatic model_step();
    logic [DIGITS+6:0] s;
    bit evt;
    int nib, idx;
    s = {dig_sel, seg_in};
    if (m_first || s != m_prev) m_run = 1;
    else if (m_run < 1000) m_run++;
    m_first = 1'b0;
    m_prev  = s;
    m_fv    = 1'b0;
    evt     = 1'b0;
    if (m_run == SETTLE + 1) begin
      if ($countones(dig_sel) > 1) evt = 1'b1;
      else if ($countones(dig_sel) == 1) begin
        idx = 0;
        for (int i = 0; i < DIGITS; i++) if (dig_sel[i]) idx = i;
        nib = lookup(seg_in);
        if (nib >= 0) begin
          m_val[idx] = nib[3:0];
          m_dv[idx] = 1'b1;
          m_seen[idx] = 1'b1;
          if (&m_seen) begin m_fv = 1'b1; m_seen = '0; end
        end else begin
          m_dv[idx] = 1'b0;
          m_seen[idx] = 1'b0;
          evt = 1'b1;
        end
      end
    end
    m_err = evt ? 1'b1 : (err_clr ? 1'b0 : m_err);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    if (check_en) begin
      check("value", 32'(value), 32'({m_val[3], m_val[2], m_val[1], m_val[0]}));
      check("digit_valid", 32'(digit_valid), 32'(m_dv));
      check("frame_valid", 32'(frame_valid), 32'(m_fv));
      check("err", 32'(err), 32'(m_err));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_value"}, 32'(value), 32'h0);
    check({tag, "_dv"}, 32'(digit_valid), 32'h0);
    check({tag, "_fv"}, 32'(frame_valid), 32'h0);
    check({tag, "_err"}, 32'(err), 32'h0);
  endtask

  initial begin
    logic [6:0] t2_pats [4];
    int fv_cnt;
    int r, hold;
    logic [DIGITS-1:0] ds;

    t2_pats = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1000111};

    rst_n = 1'b0;
    repeat (2) step();
    check_en = 1'b1;
    check_all_zero("reset");

    // Digit 3 on position 0: visible after the fourth edge, not the third.
    dig_sel = 4'b0001;
    seg_in  = 7'b1111001;
    rst_n   = 1'b1;
    repeat (3) step();
    check("t1_dv_before", 32'(digit_valid), 32'h0);
    step();
    check("t1_value", 32'(value[3:0]), 32'h3);
    check("t1_dv", 32'(digit_valid), 32'h1);
    check("t1_err", 32'(err), 32'h0);
    step();

    // Full frame 0,1,2,F: one frame_valid pulse on the fourth capture.
    fv_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      dig_sel = 4'(1 << k);
      seg_in  = t2_pats[k];
      repeat (4) begin
        step();
        if (frame_valid) fv_cnt++;
      end
    end
    check("t2_fv_at_4th", 32'(frame_valid), 32'h1);
    step();
    if (frame_valid) fv_cnt++;
    check("t2_fv_count", 32'(fv_cnt), 32'h1);
    check("t2_value", 32'(value), 32'hF210);
    check("t2_dv", 32'(digit_valid), 32'hF);

    // Toggling faster than the settle window never captures.
    dig_sel = 4'b0001;
    repeat (6) begin
      seg_in = 7'b0110000; step(); step();
      seg_in = 7'b1111111; step(); step();
    end
    check("t3_value", 32'(value), 32'hF210);
    check("t3_dv", 32'(digit_valid), 32'hF);

    // Illegal pattern on position 1.
    dig_sel = 4'b0010;
    seg_in  = 7'b0000001;
    repeat (4) step();
    check("t4_err", 32'(err), 32'h1);
    check("t4_dv", 32'(digit_valid), 32'hD);
    check("t4_value", 32'(value), 32'hF210);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    check("t4_err_clr", 32'(err), 32'h0);

    // Multi-hot select, then err_clr colliding with a new error.
    dig_sel = 4'b0011;
    seg_in  = 7'b1111110;
    repeat (4) step();
    check("t5_err", 32'(err), 32'h1);
    check("t5_value", 32'(value), 32'hF210);
    check("t5_dv", 32'(digit_valid), 32'hD);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    check("t5_err_clr", 32'(err), 32'h0);
    seg_in = 7'b0110000;
    repeat (3) step();
    check("t5_err_pre", 32'(err), 32'h0);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    check("t5_err_wins", 32'(err), 32'h1);

    // Reset after two stable cycles in SETTLING.
    dig_sel = 4'b0100;
    seg_in  = 7'b1110000;
    repeat (3) step();
    #1 rst_n = 1'b0;
    #1 check_all_zero("t6_async");
    step();
    rst_n = 1'b1;
    repeat (3) step();
    check("t6_no_capture", 32'(digit_valid), 32'h0);
    check("t6_value", 32'(value), 32'h0);

    // Randomized traffic checked by the per-cycle compare process.
    for (int s = 0; s < 400; s++) begin
      if ($urandom_range(0, 39) == 0) begin
        #1 rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end
      r = $urandom_range(0, 9);
      if (r == 0) ds = '0;
      else if (r == 1) begin
        do ds = 4'($urandom_range(0, 15)); while ($countones(ds) < 2);
      end else ds = 4'(1 << $urandom_range(0, 3));
      dig_sel = ds;
      seg_in  = ($urandom_range(0, 4) == 0) ? 7'($urandom) : pat_tab[$urandom_range(0, 15)];
      hold = $urandom_range(1, 7);
      repeat (hold) begin
        err_clr = ($urandom_range(0, 7) == 0);
        step();
      end
    end
    err_clr = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
